colour_conv_sequencer: RTL
==========================

// Module: colour_conv_sequencer
// PURPOSE
//  Parametrised read/convert sequencer for the YUV->RGB colour-conversion datapath.
//  Each group is NPIX pixels of NCH components. Per component cycle it steers the read
//  muxes, raises one-hot load enables, alternates write/temp strobes and fires a convert pulse.
//  Adds a start/done handshake, a pixel count, address generation, memory stall and pipeline drain.
// PARAMETERS
//  NCH        3      components per pixel (Y,U,V); NCH*NPIX must be even
//  NPIX       2      pixels per group (datapath lanes; lane 0 = odd pixel)
//  NUM_PIXELS 76800  pixels per frame; must be a multiple of NPIX
//  ADDR_W     18     read/write address width
//  DRAIN_CYC  2      post-frame pipeline flush cycles, >=1
// PORTS
//  clk       in   1               clock, rising edge
//  rst       in   1               asynchronous, active-high reset
//  start     in   1               frame start request, sampled in IDLE only
//  mem_ready in   1               read data valid this cycle; 0 = stall
//  clear     out  1               datapath register clear, high in IDLE
//  lane_sel  out  $clog2(NPIX)    pixel-lane mux select
//  comp_sel  out  $clog2(NCH)     component mux select (0=Y,1=U,2=V)
//  ld_en     out  NCH*NPIX        one-hot component register load
//  wr_en     out  1               output memory write strobe
//  temp_en   out  1               temp register load
//  cen       out  1               convert-group pulse
//  rd_addr   out  ADDR_W          source read address
//  wr_addr   out  ADDR_W          destination write address
//  busy      out  1               high in all states except IDLE
//  done      out  1               one-cycle frame-complete pulse
// BEHAVIOUR
//  Reset: state=IDLE, clear=1, every other output=0, all counters=0. Takes effect immediately, mid-frame too.
//  FSM: IDLE -(start)-> WAIT -> READ -> DRAIN -> DONE -> IDLE. Registered state; outputs decode state/phase.
//  IDLE: clear=1. Rising edge with start=1 zeroes phase, pixel count, rd_addr and wr_addr.
//  WAIT: one prime cycle, all strobes 0.
//  READ: phase p runs 0..NCH*NPIX-1 and wraps. lane=p/NCH, comp=p%NCH, ld_en=1<<p.
//   wr_en=1 when p is even; temp_en=1 when p is odd; cen=1 when p=NCH*NPIX-1.
//  Stall (mem_ready=0 in READ): p and addresses hold; ld_en/wr_en/temp_en/cen forced 0; selects hold.
//  rd_addr +1 on every non-stalled READ cycle. wr_addr +1 on every issued wr_en; both wrap at 2^ADDR_W.
//  Pixel count +NPIX on each issued cen. When that cen makes count==NUM_PIXELS, go to DRAIN next cycle.
//   Otherwise p wraps to 0.
//  DRAIN: DRAIN_CYC cycles, strobes 0, ignores mem_ready. DONE: done=1 for exactly one cycle, then IDLE.
//  start outside IDLE is ignored. start held high re-launches a frame after the IDLE cycle.
// CONFIGURATION
//  CCS_STALL_EN defined: mem_ready honoured as above.
//  CCS_STALL_EN undefined: mem_ready ignored (treated as 1); READ never stalls; port remains, unused.
// STRUCTURE
//  Package colour_conv_pkg: state enum (IDLE,WAIT,READ,DRAIN,DONE); COMP_Y/U/V constants.
//   Also holds the NCH/NPIX defaults.
//  Sub-module ccs_phase_counter: phase wrap counter with lane/comp decode and hold input.
//  Top holds the FSM, pixel counter, address counters and drain counter.
// TESTING (NCH=3, NPIX=2, NUM_PIXELS=4, DRAIN_CYC=2, stall enabled unless noted)
//  Reset then idle -> clear=1, busy=0, ld_en=0, done=0; start pulse at edge k -> WAIT at k+1.
//   Then READ k+2..k+13, DRAIN k+14..k+15, done=1 only at k+16, IDLE at k+17.
//  One group, no stall -> ld_en 000001..100000; wr_en on p=0,2,4; temp_en on p=1,3,5.
//   cen only on p=5; lane_sel 0,0,0,1,1,1; comp_sel 0,1,2,0,1,2.
//  mem_ready=0 for 3 cycles at p=2 -> p, rd_addr and comp_sel=2 hold; all strobes 0.
//   Frame ends 3 cycles later; final rd_addr=12, wr_addr=6.
//  rst asserted at p=4 of group 2 -> same cycle state=IDLE, clear=1, strobes 0; next start runs a full frame.
//  start pulsed during READ and DRAIN -> no effect; exactly one done pulse per frame.
//  CCS_STALL_EN undefined, mem_ready=0 throughout -> identical timing to the no-stall frame.

Source files
------------

// File: rtl/colour_conv_pkg.sv
// Shared types and defaults for the YUV->RGB read/convert sequencer.
package colour_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } ccs_state_t;

  localparam logic [1:0] COMP_Y = 2'd0;
  localparam logic [1:0] COMP_U = 2'd1;
  localparam logic [1:0] COMP_V = 2'd2;

  localparam int CCS_NCH  = 3;
  localparam int CCS_NPIX = 2;

endpackage

// File: rtl/ccs_phase_counter.sv
// Component-phase wrap counter with incrementally tracked lane/component selects.
module ccs_phase_counter
  import colour_conv_pkg::*;
#(
  parameter  int NCH  = CCS_NCH,
  parameter  int NPIX = CCS_NPIX,
  localparam int NPH  = NCH * NPIX,
  localparam int PW   = (NPH > 1) ? $clog2(NPH) : 1,
  localparam int LW   = (NPIX > 1) ? $clog2(NPIX) : 1,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [PW-1:0] phase,
  output logic [LW-1:0] lane_sel,
  output logic [CW-1:0] comp_sel,
  output logic          last
);

  assign last = (phase == PW'(NPH - 1));

  // lane/comp are stepped alongside phase so no divider is needed for p/NCH, p%NCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      lane_sel <= '0;
      comp_sel <= CW'(COMP_Y);
    end else if (clr) begin
      phase    <= '0;
      lane_sel <= '0;
      comp_sel <= CW'(COMP_Y);
    end else if (adv) begin
      if (last) begin
        phase    <= '0;
        lane_sel <= '0;
        comp_sel <= CW'(COMP_Y);
      end else begin
        phase <= phase + PW'(1);
        if (comp_sel == CW'(NCH - 1)) begin
          comp_sel <= CW'(COMP_Y);
          lane_sel <= lane_sel + LW'(1);
        end else begin
          comp_sel <= comp_sel + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/colour_conv_sequencer.sv
// Frame sequencer: start/done handshake, component strobes, address generation, drain.
// Build option: define CCS_STALL_EN to honour mem_ready stalls in READ.
module colour_conv_sequencer
  import colour_conv_pkg::*;
#(
  parameter  int NCH        = CCS_NCH,
  parameter  int NPIX       = CCS_NPIX,
  parameter  int NUM_PIXELS = 76800,
  parameter  int ADDR_W     = 18,
  parameter  int DRAIN_CYC  = 2,
  localparam int NPH        = NCH * NPIX,
  localparam int PW         = (NPH > 1) ? $clog2(NPH) : 1,
  localparam int LW         = (NPIX > 1) ? $clog2(NPIX) : 1,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_ready,
  output logic              clear,
  output logic [LW-1:0]     lane_sel,
  output logic [CW-1:0]     comp_sel,
  output logic [NPH-1:0]    ld_en,
  output logic              wr_en,
  output logic              temp_en,
  output logic              cen,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done
);

  localparam int PCW = $clog2(NUM_PIXELS + 1);
  localparam int DW  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  ccs_state_t     state;
  logic           go;
  logic           adv;
  logic           last;
  logic           launch;
  logic           frame_end;
  logic [PW-1:0]  phase;
  logic [PCW-1:0] pix_cnt;
  logic [DW-1:0]  drain_cnt;

`ifdef CCS_STALL_EN
  assign go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign go = 1'b1;
`endif

  assign launch    = (state == ST_IDLE) && start;
  assign adv       = (state == ST_READ) && go;
  assign frame_end = cen && ((pix_cnt + PCW'(NPIX)) == PCW'(NUM_PIXELS));

  ccs_phase_counter #(.NCH(NCH), .NPIX(NPIX)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .clr      (launch),
    .adv      (adv),
    .phase    (phase),
    .lane_sel (lane_sel),
    .comp_sel (comp_sel),
    .last     (last)
  );

  // strobes are gated by mem_ready in the same cycle, since read data is valid only then
  assign ld_en   = adv ? (NPH'(1) << phase) : '0;
  assign wr_en   = adv && !phase[0];
  assign temp_en = adv && phase[0];
  assign cen     = adv && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      clear     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_WAIT;
          clear <= 1'b0;
          busy  <= 1'b1;
        end
        ST_WAIT: state <= ST_READ;
        ST_READ: if (frame_end) begin
          state     <= ST_DRAIN;
          drain_cnt <= DW'(DRAIN_CYC - 1);
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          clear <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          clear <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
    end else if (launch) begin
      pix_cnt <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
    end else begin
      if (adv) rd_addr <= rd_addr + ADDR_W'(1);
      if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);
      if (cen) pix_cnt <= pix_cnt + PCW'(NPIX);
    end
  end

endmodule
